result_align_checker: RTL

- Synthesizable downstream consumer of the CPU DUV and its reference model. It buffers the result stream from each side, pairs results in order, and compares opcode and result.
- It counts compares and mismatches, captures the first mismatching pair, and flags overflow and alignment timeouts.
- It sits beside the scoreboard on the same bus. It gives a cycle-accurate, always-on hardware check that can also run in emulation.

---
 rtl/result_align_checker_pkg.sv | 13 +
 rtl/result_align_checker_fifo.sv | 62 ++++++
 rtl/result_align_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/result_align_checker_pkg.sv
// Shared widths, payload struct and checker state encoding for the result
// alignment checker and its FIFOs.
package def;
    localparam int OP_W  = 8;
    localparam int RES_W = 32;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RES_W-1:0] res;
    } res_t;

    typedef enum logic [1:0] {IDLE, WAIT, CMP, ERR} chk_state_e;
endpackage

// File: rtl/result_align_checker_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read from the entry
// addressed by the registered read pointer.
module result_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = def::res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty,
    output logic empty_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign empty_next = (wr_ptr_d == rd_ptr_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/result_align_checker.sv
// Pairs DUV and reference results in order, compares them, and keeps
// counters, first-mismatch capture, overflow and alignment-timeout flags.
module result_align_checker
    import def::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16,
    parameter int OP_W    = def::OP_W,
    parameter int RES_W   = def::RES_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  duv_valid,
    input  logic [OP_W-1:0]       duv_op,
    input  logic [RES_W-1:0]      duv_res,
    input  logic                  ref_valid,
    input  logic [OP_W-1:0]       ref_op,
    input  logic [RES_W-1:0]      ref_res,
    input  logic                  clear,
    output logic                  cmp_valid,
    output logic                  cmp_match,
    output logic [OP_W-1:0]       cmp_op,
    output logic [CNT_W-1:0]      compare_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  first_bad_valid,
    output logic [OP_W+RES_W-1:0] first_bad_duv,
    output logic [OP_W+RES_W-1:0] first_bad_ref,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RES_W-1:0] res;
    } pair_t;

    pair_t duv_head, ref_head;
    logic  duv_full, duv_empty, duv_empty_nx;
    logic  ref_full, ref_empty, ref_empty_nx;
    logic  pop, mismatch;

    chk_state_e         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               cmp_valid_q, cmp_valid_d, cmp_match_q, cmp_match_d;
    logic [OP_W-1:0]    cmp_op_q, cmp_op_d;
    logic [CNT_W-1:0]   compare_cnt_q, compare_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
    logic               first_bad_valid_q, first_bad_valid_d;
    pair_t              first_bad_duv_q, first_bad_duv_d, first_bad_ref_q, first_bad_ref_d;
    logic               overflow_q, overflow_d, timeout_q, timeout_d;

    result_fifo #(.DEPTH(DEPTH), .T(pair_t)) u_duv_fifo (
        .clk(clk), .rst_n(rst_n), .flush(clear),
        .push(duv_valid && !clear), .pop(pop), .din({duv_op, duv_res}),
        .head(duv_head), .full(duv_full), .empty(duv_empty), .empty_next(duv_empty_nx)
    );

    result_fifo #(.DEPTH(DEPTH), .T(pair_t)) u_ref_fifo (
        .clk(clk), .rst_n(rst_n), .flush(clear),
        .push(ref_valid && !clear), .pop(pop), .din({ref_op, ref_res}),
        .head(ref_head), .full(ref_full), .empty(ref_empty), .empty_next(ref_empty_nx)
    );

    assign pop      = !clear && (state_q != ERR) && !duv_empty && !ref_empty;
    assign mismatch = pop && (duv_head != ref_head);

    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        cmp_valid_d       = pop;
        cmp_match_d       = pop && !mismatch;
        cmp_op_d          = pop ? duv_head.op : '0;
        compare_cnt_d     = compare_cnt_q;
        mismatch_cnt_d    = mismatch_cnt_q;
        first_bad_valid_d = first_bad_valid_q;
        first_bad_duv_d   = first_bad_duv_q;
        first_bad_ref_d   = first_bad_ref_q;
        overflow_d        = overflow_q | (duv_valid && duv_full && !pop)
                                       | (ref_valid && ref_full && !pop);
        timeout_d         = timeout_q;

        if (pop && (compare_cnt_q != '1))       compare_cnt_d  = compare_cnt_q + 1'b1;
        if (mismatch && (mismatch_cnt_q != '1)) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        if (mismatch && !first_bad_valid_q) begin
            first_bad_valid_d = 1'b1;
            first_bad_duv_d   = duv_head;
            first_bad_ref_d   = ref_head;
        end

        // Next state follows the occupancy the FIFOs will have after this edge.
        if (state_q != ERR) begin
            if (!duv_empty_nx && !ref_empty_nx) begin
                state_d = CMP;
                timer_d = '0;
            end else if (duv_empty_nx && ref_empty_nx) begin
                state_d = IDLE;
                timer_d = '0;
            end else if (state_q == WAIT) begin
                timer_d = timer_q + 1'b1;
                if (timer_d == TW'(TIMEOUT)) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                end
            end else begin
                state_d = WAIT;
                timer_d = '0;
            end
        end

        if (clear) begin
            state_d           = IDLE;
            timer_d           = '0;
            cmp_valid_d       = 1'b0;
            cmp_match_d       = 1'b0;
            cmp_op_d          = '0;
            compare_cnt_d     = '0;
            mismatch_cnt_d    = '0;
            first_bad_valid_d = 1'b0;
            first_bad_duv_d   = '0;
            first_bad_ref_d   = '0;
            overflow_d        = 1'b0;
            timeout_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            timer_q           <= '0;
            cmp_valid_q       <= 1'b0;
            cmp_match_q       <= 1'b0;
            cmp_op_q          <= '0;
            compare_cnt_q     <= '0;
            mismatch_cnt_q    <= '0;
            first_bad_valid_q <= 1'b0;
            first_bad_duv_q   <= '0;
            first_bad_ref_q   <= '0;
            overflow_q        <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            cmp_valid_q       <= cmp_valid_d;
            cmp_match_q       <= cmp_match_d;
            cmp_op_q          <= cmp_op_d;
            compare_cnt_q     <= compare_cnt_d;
            mismatch_cnt_q    <= mismatch_cnt_d;
            first_bad_valid_q <= first_bad_valid_d;
            first_bad_duv_q   <= first_bad_duv_d;
            first_bad_ref_q   <= first_bad_ref_d;
            overflow_q        <= overflow_d;
            timeout_q         <= timeout_d;
        end
    end

    assign cmp_valid       = cmp_valid_q;
    assign cmp_match       = cmp_match_q;
    assign cmp_op          = cmp_op_q;
    assign compare_cnt     = compare_cnt_q;
    assign mismatch_cnt    = mismatch_cnt_q;
    assign first_bad_valid = first_bad_valid_q;
    assign first_bad_duv   = first_bad_duv_q;
    assign first_bad_ref   = first_bad_ref_q;
    assign overflow        = overflow_q;
    assign timeout         = timeout_q;
    assign busy            = !duv_empty || !ref_empty;
endmodule
